mor1kx_branch_predictor_tournament: RTL
=======================================

Name: mor1kx_branch_predictor_tournament

Overview:
Parametrised hybrid conditional-branch predictor for the mor1kx cappuccino pipeline. It holds a PC-indexed bimodal table, a gshare table indexed by PC XOR global history, and a chooser table that selects between the two per PC. The decode stage gets a predicted flag for l.bf/l.bnf; each branch trains all three tables when it resolves in execute. It also provides a saturating misprediction count for performance monitoring.

Parameters:
OPTION_OPERAND_WIDTH, 32, width of the PC.
PHT_INDEX_WIDTH, 6, log2 entries of each table (bimodal, gshare, chooser); legal range 2..12.
GHR_WIDTH, 6, global history length; must be <= PHT_INDEX_WIDTH; elaboration error (display + finish) otherwise.
CNT_WIDTH, 2, saturating counter width of every table entry; legal range 1..4.
PERF_CNT_WIDTH, 16, width of the misprediction counter.

Ports:
clk  in  1  clock; all state is rising-edge.
rst_n  in  1  asynchronous, active-low reset.
op_bf_i  in  1  decode stage: instruction is l.bf.
op_bnf_i  in  1  decode stage: instruction is l.bnf.
brn_pc_i  in  OPTION_OPERAND_WIDTH  PC of the decode-stage branch.
padv_decode_i  in  1  decode stage advances this cycle.
prev_op_brcond_i  in  1  decode-execute stage holds a conditional branch.
execute_op_bf_i  in  1  branch in execute is l.bf.
execute_op_bnf_i  in  1  branch in execute is l.bnf.
flag_i  in  1  resolved SR[F] for the execute-stage branch.
branch_mispredict_i  in  1  misprediction indication for the execute-stage branch.
predicted_flag_o  out  1  predicted flag for the decode-stage branch.
mispredict_cnt_o  out  PERF_CNT_WIDTH  saturating count of mispredictions.

Behaviour:
- Index definitions: bidx = brn_pc_i[PHT_INDEX_WIDTH+1:2]; gidx = bidx XOR {zero-pad, ghr}. GHR bits occupy the low bits of gidx.
- Prediction is combinational from the current table contents. A component predicts taken when its counter MSB is 1. The chooser selects gshare when its MSB is 1, else bimodal.
- Output encoding: predicted_flag_o = taken XOR op_bnf_i. predicted_flag_o is 0 when neither op_bf_i nor op_bnf_i is set.
- Capture: when padv_decode_i & (op_bf_i | op_bnf_i), register bidx, gidx, the bimodal prediction bit and the gshare prediction bit for use at resolution. Captured values hold while padv_decode_i=0.
- Update strobe upd = prev_op_brcond_i & padv_decode_i. There is exactly one update per branch; stalls produce no repeat updates.
- actual_taken = flag_i XOR execute_op_bnf_i. execute_op_bf_i is informational only.
- On upd, in one clock edge:
  - Bimodal[cap_bidx] increments when actual_taken, else decrements.
  - Gshare[cap_gidx] increments when actual_taken, else decrements.
  - Chooser[cap_bidx] changes only when the captured component predictions differ: increment if gshare was correct, decrement if bimodal was correct.
  - ghr <= {ghr[GHR_WIDTH-2:0], actual_taken}. History is non-speculative. For GHR_WIDTH=1, ghr <= actual_taken.
- Saturation: counters clamp at 0 and 2^CNT_WIDTH-1. No wrap-around.
- Same-cycle read/write of one entry: prediction uses the pre-update value; no bypass.
- Same-cycle capture and update: both occur. Update uses the previously captured indices; capture loads the new ones.
- mispredict_cnt_o increments on upd & branch_mispredict_i and saturates at all-ones.
- Reset (async assert, any time including mid-update):
  - Bimodal and gshare entries go to 2^(CNT_WIDTH-1), weakly taken.
  - Chooser entries go to 2^(CNT_WIDTH-1)-1, weakly bimodal. For CNT_WIDTH=1 this is 0.
  - ghr, captured registers and mispredict_cnt_o go to 0.
  - Reset state is visible immediately on predicted_flag_o.
- Tables are flop arrays so every entry has a defined reset. Expected size is ~250 RTL lines.

Test Plan:
1. Reset, then l.bf at PC 0x100 -> predicted_flag_o=1 (weakly taken via bimodal). l.bnf at the same PC -> 0. Neither op -> 0. mispredict_cnt_o=0.
2. Three l.bf at PC 0x100 resolved not-taken (flag_i=0, upd each) -> bimodal[0] saturates at 0. Next l.bf at 0x100 predicts flag 0. A fourth not-taken update leaves the counter at 0.
3. Alternating T/N branch at PC 0x40, 40 iterations, defaults -> chooser[0x10] reaches 3 (gshare). The last 10 predictions must all be correct.
4. Stall with padv_decode_i=0 for 5 cycles while prev_op_brcond_i=1 -> no table, ghr or counter change. Counters update once on the cycle padv_decode_i rises.
5. PERF_CNT_WIDTH=2, 5 updates with branch_mispredict_i=1 -> mispredict_cnt_o sequence 1, 2, 3, 3, 3.
6. Assert rst_n=0 mid-update on a non-clock edge -> all tables return to reset values at once. ghr=0 and predicted_flag_o reflects reset state before the next clk.

Source files
------------

// File: rtl/mor1kx_branch_predictor_tournament.sv
// Tournament conditional-branch predictor for the mor1kx cappuccino pipeline.
// It combines a bimodal table, a gshare table and a per-PC chooser, and keeps a saturating mispredict count.
module mor1kx_branch_predictor_tournament #(
  parameter int unsigned OPTION_OPERAND_WIDTH = 32,
  parameter int unsigned PHT_INDEX_WIDTH      = 6,
  parameter int unsigned GHR_WIDTH            = 6,
  parameter int unsigned CNT_WIDTH            = 2,
  parameter int unsigned PERF_CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
  input  logic                            padv_decode_i,
  input  logic                            prev_op_brcond_i,
  input  logic                            execute_op_bf_i,
  input  logic                            execute_op_bnf_i,
  input  logic                            flag_i,
  input  logic                            branch_mispredict_i,
  output logic                            predicted_flag_o,
  output logic [PERF_CNT_WIDTH-1:0]       mispredict_cnt_o
);

  localparam int unsigned N_ENTRIES = 1 << PHT_INDEX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] WEAK_TAKEN = CNT_WIDTH'(2 ** (CNT_WIDTH - 1));
  localparam logic [CNT_WIDTH-1:0] WEAK_BIM   = CNT_WIDTH'(2 ** (CNT_WIDTH - 1) - 1);

  // Reject illegal parameter combinations at elaboration.
  if (GHR_WIDTH < 1 || GHR_WIDTH > PHT_INDEX_WIDTH) begin : g_bad_ghr
    $fatal(1, "GHR_WIDTH (%0d) must be in 1..PHT_INDEX_WIDTH (%0d)", GHR_WIDTH, PHT_INDEX_WIDTH);
  end
  if (PHT_INDEX_WIDTH < 2 || PHT_INDEX_WIDTH > 12) begin : g_bad_pht
    $fatal(1, "PHT_INDEX_WIDTH (%0d) must be in 2..12", PHT_INDEX_WIDTH);
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 4) begin : g_bad_cnt
    $fatal(1, "CNT_WIDTH (%0d) must be in 1..4", CNT_WIDTH);
  end

  logic [N_ENTRIES-1:0][CNT_WIDTH-1:0] bim_tbl;
  logic [N_ENTRIES-1:0][CNT_WIDTH-1:0] gsh_tbl;
  logic [N_ENTRIES-1:0][CNT_WIDTH-1:0] cho_tbl;
  logic [GHR_WIDTH-1:0]                ghr;
  logic [GHR_WIDTH-1:0]                ghr_next;

  logic [PHT_INDEX_WIDTH-1:0] bidx;
  logic [PHT_INDEX_WIDTH-1:0] gidx;
  logic                       bim_taken;
  logic                       gsh_taken;
  logic                       use_gsh;
  logic                       pred_taken;

  logic [PHT_INDEX_WIDTH-1:0] cap_bidx;
  logic [PHT_INDEX_WIDTH-1:0] cap_gidx;
  logic                       cap_bim_taken;
  logic                       cap_gsh_taken;

  logic upd;
  logic capture;
  logic actual_taken;
  logic chooser_train;
  logic unused_inputs;

  function automatic logic [CNT_WIDTH-1:0] cnt_step(input logic [CNT_WIDTH-1:0] c,
                                                    input logic up);
    logic [CNT_WIDTH-1:0] r;
    r = c;
    if (up && c != CNT_MAX)
      r = c + CNT_WIDTH'(1);
    else if (!up && c != '0)
      r = c - CNT_WIDTH'(1);
    return r;
  endfunction

  // Combinational prediction from current table contents (no write bypass).
  assign bidx       = brn_pc_i[PHT_INDEX_WIDTH+1:2];
  assign gidx       = bidx ^ PHT_INDEX_WIDTH'(ghr);
  assign bim_taken  = bim_tbl[bidx][CNT_WIDTH-1];
  assign gsh_taken  = gsh_tbl[gidx][CNT_WIDTH-1];
  assign use_gsh    = cho_tbl[bidx][CNT_WIDTH-1];
  assign pred_taken = use_gsh ? gsh_taken : bim_taken;

  assign predicted_flag_o = (op_bf_i | op_bnf_i) & (pred_taken ^ op_bnf_i);

  assign upd           = prev_op_brcond_i & padv_decode_i;
  assign capture       = padv_decode_i & (op_bf_i | op_bnf_i);
  assign actual_taken  = flag_i ^ execute_op_bnf_i;
  assign chooser_train = cap_bim_taken ^ cap_gsh_taken;

  // The execute-stage l.bf strobe carries no information beyond l.bnf.
  assign unused_inputs = ^{brn_pc_i, execute_op_bf_i};

  if (GHR_WIDTH == 1) begin : g_ghr_one
    assign ghr_next = actual_taken;
  end else begin : g_ghr_multi
    assign ghr_next = {ghr[GHR_WIDTH-2:0], actual_taken};
  end

  // Decode-time snapshot of indices and component predictions for training.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_bidx      <= '0;
      cap_gidx      <= '0;
      cap_bim_taken <= 1'b0;
      cap_gsh_taken <= 1'b0;
    end else if (capture) begin
      cap_bidx      <= bidx;
      cap_gidx      <= gidx;
      cap_bim_taken <= bim_taken;
      cap_gsh_taken <= gsh_taken;
    end
  end

  // Training of all three tables and the non-speculative history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bim_tbl <= {N_ENTRIES{WEAK_TAKEN}};
      gsh_tbl <= {N_ENTRIES{WEAK_TAKEN}};
      cho_tbl <= {N_ENTRIES{WEAK_BIM}};
      ghr     <= '0;
    end else if (upd) begin
      bim_tbl[cap_bidx] <= cnt_step(bim_tbl[cap_bidx], actual_taken);
      gsh_tbl[cap_gidx] <= cnt_step(gsh_tbl[cap_gidx], actual_taken);
      if (chooser_train)
        cho_tbl[cap_bidx] <= cnt_step(cho_tbl[cap_bidx], cap_gsh_taken == actual_taken);
      ghr <= ghr_next;
    end
  end

  // Saturating misprediction counter for performance monitoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mispredict_cnt_o <= '0;
    else if (upd && branch_mispredict_i && mispredict_cnt_o != {PERF_CNT_WIDTH{1'b1}})
      mispredict_cnt_o <= mispredict_cnt_o + PERF_CNT_WIDTH'(1);
  end

endmodule
